// File: rtl/led_step_if.sv
// Button inputs and step/rate/pause outputs of the LED pacing stage.
// The slave modport is the view taken by led_step_ctrl.
interface led_step_if;
  logic       btn_speed;
  logic       btn_pause;
  logic       step;
  logic [1:0] speed_sel;
  logic       paused;

  modport master (
    output btn_speed, btn_pause,
    input  step, speed_sel, paused
  );

  modport slave (
    input  btn_speed, btn_pause,
    output step, speed_sel, paused
  );
endinterface

// File: rtl/led_step_ctrl.sv
// Step-strobe generator for the 4-LED chaser: debounced speed/pause buttons,
// four selectable rates and a pause/run FSM gating a programmable divider.
module led_step_ctrl #(
  parameter int DIV_BASE  = 4_000_000,
  parameter int DIV_WIDTH = 26,
  parameter int DB_CYCLES = 500_000,
  parameter int DB_WIDTH  = 20
) (
  input  logic       clk,
  input  logic       rst,
  led_step_if.slave  if_led
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_PAUSED = 1'b1
  } run_state_t;

  localparam int IDX_SPEED = 0;
  localparam int IDX_PAUSE = 1;
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_CYCLES - 1);

  logic [1:0]          w_btn_raw;
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          r_db_lvl;
  logic [1:0]          r_db_prev;
  logic [DB_WIDTH-1:0] r_db_cnt [2];
  logic [1:0]          w_press;

  run_state_t          r_state;
  run_state_t          w_state_nxt;
  logic                w_advance;

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_period_m1;
  logic                 r_step;
  logic [1:0]           r_sel;

  function automatic logic [DIV_WIDTH-1:0] period_m1(input logic [1:0] sel);
    return (DIV_WIDTH'(DIV_BASE) << (2'd3 - sel)) - DIV_WIDTH'(1);
  endfunction

  assign w_btn_raw = {if_led.btn_pause, if_led.btn_speed};

  // Synchronise, then require DB_CYCLES consecutive disagreeing samples to flip a level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db_lvl  <= '0;
      r_db_prev <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync1   <= w_btn_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_lvl;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_db_lvl[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_LAST) begin
          r_db_lvl[b] <= r_sync2[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + DB_WIDTH'(1);
        end
      end
    end
  end

  assign w_press = r_db_lvl & ~r_db_prev;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // The divider moves whenever the cycle ends in RUN, so a resume edge already counts
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      S_RUN:    if (w_press[IDX_PAUSE]) w_state_nxt = S_PAUSED;
      S_PAUSED: if (w_press[IDX_PAUSE]) w_state_nxt = S_RUN;
      default:  w_state_nxt = S_RUN;
    endcase
    if ((w_state_nxt == S_RUN) && !w_press[IDX_SPEED]) w_advance = 1'b1;
  end

  assign w_period_m1 = period_m1(r_sel);

  // A speed press restarts the period and swallows any step due on that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
      r_sel  <= 2'd0;
    end else begin
      r_step <= 1'b0;
      if (w_press[IDX_SPEED]) begin
        r_sel <= r_sel + 2'd1;
        r_cnt <= '0;
      end else if (w_advance) begin
        if (r_cnt == w_period_m1) begin
          r_cnt  <= '0;
          r_step <= 1'b1;
        end else begin
          r_cnt <= r_cnt + DIV_WIDTH'(1);
        end
      end
    end
  end

  assign if_led.step      = r_step;
  assign if_led.speed_sel = r_sel;
  assign if_led.paused    = (r_state == S_PAUSED);

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with a window-based behavioural model
// checked every cycle, plus literal timing expectations for each scenario.
module tb_led_step_ctrl;
  localparam int DIV_BASE = 4;
  localparam int DB       = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_step_if bus();

  led_step_ctrl #(
    .DIV_BASE (DIV_BASE),
    .DIV_WIDTH(26),
    .DB_CYCLES(DB),
    .DB_WIDTH (20)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .if_led(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model state
  int m_sel, m_cnt;
  bit m_paused, m_step;
  bit m_lvl_s, m_lvl_p, m_pend_s, m_pend_p;
  bit hs[$];
  bit hp[$];

  // observation bookkeeping
  int edge_no = 0;
  int step_abs[$];
  int sel_edge = -1;
  int paused_edge = -1;
  logic [1:0] last_sel = 2'd0;
  logic last_paused = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_no, act, exp);
    end
  endtask

  function automatic bit window_flip(input int which, input bit lvl);
    // True when the synchronised samples of the last DB cycles all disagree with lvl
    bit ok;
    int sz;
    ok = 1'b1;
    sz = (which == 0) ? hs.size() : hp.size();
    for (int k = 2; k <= DB + 1; k++) begin
      if (which == 0) begin
        if (hs[sz-1-k] == lvl) ok = 1'b0;
      end else begin
        if (hp[sz-1-k] == lvl) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  task automatic model_edge(input bit s, input bit p, input bit r);
    bit press_s, press_p, fs, fp;
    int per;
    if (r) begin
      m_sel = 0; m_cnt = 0; m_paused = 0; m_step = 0;
      m_lvl_s = 0; m_lvl_p = 0; m_pend_s = 0; m_pend_p = 0;
      hs = {}; hp = {};
      repeat (DB + 2) begin hs.push_back(1'b0); hp.push_back(1'b0); end
      return;
    end
    hs.push_back(s); hp.push_back(p);
    if (hs.size() > 16) begin void'(hs.pop_front()); void'(hp.pop_front()); end
    press_s = m_pend_s;
    press_p = m_pend_p;
    fs = window_flip(0, m_lvl_s);
    fp = window_flip(1, m_lvl_p);
    m_pend_s = fs && !m_lvl_s;
    m_pend_p = fp && !m_lvl_p;
    if (fs) m_lvl_s = !m_lvl_s;
    if (fp) m_lvl_p = !m_lvl_p;
    per = DIV_BASE << (3 - m_sel);
    if (press_p) m_paused = !m_paused;
    if (press_s) begin
      m_sel = (m_sel + 1) % 4; m_cnt = 0; m_step = 0;
    end else if (!m_paused) begin
      if (m_cnt == per - 1) begin m_cnt = 0; m_step = 1; end
      else begin m_cnt = m_cnt + 1; m_step = 0; end
    end else begin
      m_step = 0;
    end
  endtask

  task automatic cyc(input bit s, input bit p, input bit r);
    bus.btn_speed = s;
    bus.btn_pause = p;
    rst = r;
    @(posedge clk);
    model_edge(s, p, r);
    edge_no++;
    @(negedge clk);
    chk("step", 32'(bus.step), 32'(m_step));
    chk("speed_sel", 32'(bus.speed_sel), 32'(m_sel));
    chk("paused", 32'(bus.paused), 32'(m_paused));
    if (bus.step === 1'b1) step_abs.push_back(edge_no);
    if (bus.speed_sel !== last_sel) sel_edge = edge_no;
    if (bus.paused !== last_paused) paused_edge = edge_no;
    last_sel = bus.speed_sel;
    last_paused = bus.paused;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  function automatic int first_after(input int e);
    foreach (step_abs[i]) if (step_abs[i] > e) return step_abs[i];
    return -1;
  endfunction

  int exp_sel [4] = '{1, 2, 3, 0};
  int exp_per [4] = '{16, 8, 4, 32};

  initial begin
    int rel0, n, s1, s2, r_edge;

    // 1: reset and free-running at the slowest rate
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("rst_step", 32'(bus.step), 0);
    chk("rst_sel", 32'(bus.speed_sel), 0);
    chk("rst_paused", 32'(bus.paused), 0);
    rel0 = edge_no + 1;
    run(100);
    chk("t1_steps", step_abs.size(), 3);
    chk("t1_step0", first_after(rel0 - 1) - rel0, 31);
    chk("t1_step1", first_after(rel0 + 31) - rel0, 63);
    chk("t1_step2", first_after(rel0 + 63) - rel0, 95);

    // 2: four speed presses stepping through all rates
    for (int i = 0; i < 4; i++) begin
      n = edge_no + 1;
      repeat (10) cyc(1, 0, 0);
      repeat (10) cyc(0, 0, 0);
      run(60);
      chk("t2_press_lat", sel_edge - n, 5);
      chk("t2_sel", 32'(bus.speed_sel), exp_sel[i]);
      s1 = first_after(sel_edge);
      s2 = first_after(s1);
      chk("t2_first_step", s1 - sel_edge, exp_per[i]);
      chk("t2_period", s2 - s1, exp_per[i]);
    end

    // 3: glitches too short to pass the debouncer
    n = edge_no;
    repeat (4) begin
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
    end
    run(70);
    chk("t3_sel", 32'(bus.speed_sel), 0);
    chk("t3_no_sel_change", 32'(sel_edge < n), 1);
    s1 = first_after(n);
    chk("t3_period", first_after(s1) - s1, 32);

    // 4: pause at count 10, hold 100 cycles, resume
    for (int i = 0; i < 64 && m_cnt != 5; i++) cyc(0, 0, 0);
    n = edge_no + 1;
    repeat (10) cyc(0, 1, 0);
    run(100);
    chk("t4_pause_lat", paused_edge - n, 5);
    chk("t4_paused", 32'(bus.paused), 1);
    chk("t4_no_step", first_after(n + 5), -1);
    n = edge_no + 1;
    repeat (10) cyc(0, 1, 0);
    run(30);
    chk("t4_resume_lat", paused_edge - n, 5);
    chk("t4_resume_step", first_after(n + 5) - (n + 5), 21);

    // 5: pause and speed presses land on the step cycle
    for (int i = 0; i < 64 && m_cnt != 26; i++) cyc(0, 0, 0);
    n = edge_no + 1;
    repeat (10) cyc(1, 1, 0);
    run(10);
    chk("t5_sel_edge", sel_edge - n, 5);
    chk("t5_paused_edge", paused_edge - n, 5);
    chk("t5_no_step", first_after(n + 4), -1);
    chk("t5_sel", 32'(bus.speed_sel), 1);
    chk("t5_paused", 32'(bus.paused), 1);

    // speed press while paused, then resume and pause again with the button held
    repeat (10) cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    chk("t6_sel_pre", 32'(bus.speed_sel), 2);
    chk("t6_paused_pre", 32'(bus.paused), 1);
    repeat (10) cyc(0, 1, 0);
    repeat (10) cyc(0, 0, 0);
    run(5);
    repeat (8) cyc(0, 1, 0);
    chk("t6_paused_held", 32'(bus.paused), 1);

    // 6: one-cycle reset with btn_pause still held
    cyc(0, 1, 1);
    r_edge = edge_no;
    chk("t6_rst_step", 32'(bus.step), 0);
    chk("t6_rst_sel", 32'(bus.speed_sel), 0);
    chk("t6_rst_paused", 32'(bus.paused), 0);
    repeat (12) cyc(0, 1, 0);
    chk("t6_repress_lat", paused_edge - (r_edge + 1), 5);
    chk("t6_paused_post", 32'(bus.paused), 1);
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
